// File: rtl/telemetry_tx.sv
// Snapshots attitude/duty inputs and sends them as one UART 8N1 frame: AA 55, 17 payload bytes, optional checksum (TELEM_CHECKSUM_EN).
// Latency: start bit of byte 0 begins the cycle after send_start is accepted; one bit lasts CLK_FREQ/BAUD clocks.
// Backpressure: none; send_start while busy is dropped and flagged on overrun in the same cycle.
module telemetry_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send_start,
  input  logic [23:0] cur_pitch,
  input  logic [23:0] cur_roll,
  input  logic [23:0] cur_yaw,
  input  logic [15:0] pwm_duty_1,
  input  logic [15:0] pwm_duty_2,
  input  logic [15:0] pwm_duty_3,
  input  logic [15:0] pwm_duty_4,
  output logic        TxD,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef TELEM_CHECKSUM_EN
  localparam int NBYTES   = 20;
`else
  localparam int NBYTES   = 19;
`endif
  localparam logic [4:0] LAST_IDX = 5'(NBYTES - 1);

  typedef struct packed {
    logic [23:0] pitch;
    logic [23:0] roll;
    logic [23:0] yaw;
    logic [15:0] duty_1;
    logic [15:0] duty_2;
    logic [15:0] duty_3;
    logic [15:0] duty_4;
  } snap_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [4:0]  byte_idx;
  logic [7:0]  shreg;
  snap_t       snap;
  logic [4:0]  next_idx;
  logic [7:0]  next_byte;
  logic        bit_end;
`ifdef TELEM_CHECKSUM_EN
  logic [7:0]  csum;
  logic        next_is_payload;
  assign next_is_payload = (next_idx >= 5'd2) && (next_idx <= 5'd18);
`endif

  assign bit_end  = (baud_cnt == CW'(BAUD_DIV - 1));
  assign next_idx = byte_idx + 5'd1;
  assign overrun  = send_start & busy;

  // Byte 0 (0xAA) is loaded directly on acceptance, so only bytes 1.. are muxed here.
  always_comb begin
    next_byte = 8'h00;
    case (next_idx)
      5'd1:    next_byte = 8'h55;
      5'd2:    next_byte = snap.pitch[23:16];
      5'd3:    next_byte = snap.pitch[15:8];
      5'd4:    next_byte = snap.pitch[7:0];
      5'd5:    next_byte = snap.roll[23:16];
      5'd6:    next_byte = snap.roll[15:8];
      5'd7:    next_byte = snap.roll[7:0];
      5'd8:    next_byte = snap.yaw[23:16];
      5'd9:    next_byte = snap.yaw[15:8];
      5'd10:   next_byte = snap.yaw[7:0];
      5'd11:   next_byte = snap.duty_1[15:8];
      5'd12:   next_byte = snap.duty_1[7:0];
      5'd13:   next_byte = snap.duty_2[15:8];
      5'd14:   next_byte = snap.duty_2[7:0];
      5'd15:   next_byte = snap.duty_3[15:8];
      5'd16:   next_byte = snap.duty_3[7:0];
      5'd17:   next_byte = snap.duty_4[15:8];
      5'd18:   next_byte = snap.duty_4[7:0];
`ifdef TELEM_CHECKSUM_EN
      5'd19:   next_byte = csum;
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      shreg      <= '0;
      snap       <= '0;
      TxD        <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef TELEM_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          TxD      <= 1'b1;
          baud_cnt <= '0;
          if (send_start) begin
            snap     <= {cur_pitch, cur_roll, cur_yaw,
                         pwm_duty_1, pwm_duty_2, pwm_duty_3, pwm_duty_4};
            state    <= START;
            TxD      <= 1'b0;
            busy     <= 1'b1;
            byte_idx <= '0;
            bit_cnt  <= '0;
            shreg    <= 8'hAA;
`ifdef TELEM_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            bit_cnt  <= '0;
            TxD      <= shreg[0];
            shreg    <= {1'b0, shreg[7:1]};
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              TxD   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              TxD     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_IDX) begin
              state      <= IDLE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              // Straight into the next start bit: no idle gap inside a frame.
              state    <= START;
              TxD      <= 1'b0;
              byte_idx <= next_idx;
              shreg    <= next_byte;
`ifdef TELEM_CHECKSUM_EN
              if (next_is_payload) csum <= csum + next_byte;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
